// File: rtl/dsc_queue_retry_manager_pkg.sv
// Shared constants and output record for the descriptor queue retry manager.
package dsc_queue_retry_manager_pkg;

    // Record field widths, sized for the default manager configuration.
    localparam int unsigned DSC_META_W = 128;
    localparam int unsigned DSC_QID_W  = 4;
    localparam int unsigned DSC_SLOT_W = 6;

    // One output beat: metadata plus the descriptor write it carries, if any.
    typedef struct packed {
        logic [DSC_META_W-1:0] meta;
        logic                  needs_dsc;
        logic [DSC_QID_W-1:0]  queue_id;
        logic [DSC_SLOT_W-1:0] slot;
        logic                  is_retry;
    } dsc_out_rec_t;

endpackage

// File: rtl/dsc_queue_retry_manager_rr_pending_arbiter.sv
// Round-robin picker over queues holding a deferred descriptor that can now be written.
module rr_pending_arbiter #(
    parameter int unsigned NB_QUEUES = 16,
    localparam int unsigned QW = $clog2(NB_QUEUES)
) (
    input  logic [NB_QUEUES-1:0] req_i,
    input  logic [QW-1:0]        last_i,
    output logic [QW-1:0]        gnt_idx_c_o,
    output logic                 gnt_valid_c_o
);

    // Search starts at the queue after the last granted one and wraps to 0.
    always_comb begin
        gnt_idx_c_o   = '0;
        gnt_valid_c_o = 1'b0;
        for (int unsigned k = 1; k <= NB_QUEUES; k++) begin
            if (!gnt_valid_c_o && req_i[QW'((32'(last_i) + k) % NB_QUEUES)]) begin
                gnt_valid_c_o = 1'b1;
                gnt_idx_c_o   = QW'((32'(last_i) + k) % NB_QUEUES);
            end
        end
    end

endmodule

// File: rtl/dsc_queue_retry_manager.sv
// Assigns descriptor ring slots to packets; defers one descriptor per full queue and retries it later.
module dsc_queue_retry_manager
    import dsc_queue_retry_manager_pkg::*;
#(
    parameter int unsigned NB_QUEUES   = 16,
    parameter int unsigned DSC_Q_DEPTH = 64,
    parameter int unsigned META_WIDTH  = 128,
    localparam int unsigned QW = $clog2(NB_QUEUES),
    localparam int unsigned AW = $clog2(DSC_Q_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [META_WIDTH-1:0] in_meta_data,
    input  logic                  in_needs_dsc,
    input  logic [QW-1:0]         in_dsc_queue_id,
    input  logic                  in_meta_valid,
    output logic                  in_meta_ready,
    output logic [META_WIDTH-1:0] out_meta_data,
    output logic                  out_needs_dsc,
    output logic [QW-1:0]         out_dsc_queue_id,
    output logic [AW-1:0]         out_dsc_slot,
    output logic                  out_is_retry,
    output logic                  out_meta_valid,
    input  logic                  out_meta_ready,
    input  logic                  head_wr_valid,
    input  logic [QW-1:0]         head_wr_queue_id,
    input  logic [AW-1:0]         head_wr_value,
    output logic [31:0]           full_cnt,
    output logic [31:0]           retry_cnt
);

    logic [AW-1:0]         tail_q  [NB_QUEUES];
    logic [AW-1:0]         tail_d  [NB_QUEUES];
    logic [AW-1:0]         head_q  [NB_QUEUES];
    logic [AW-1:0]         head_d  [NB_QUEUES];
    logic [META_WIDTH-1:0] pmeta_q [NB_QUEUES];
    logic [META_WIDTH-1:0] pmeta_d [NB_QUEUES];
    logic [NB_QUEUES-1:0]  pend_q, pend_d;
    dsc_out_rec_t          out_q, out_d;
    logic                  out_valid_q, out_valid_d;
    logic [31:0]           full_cnt_q, full_cnt_d;
    logic [31:0]           retry_cnt_q, retry_cnt_d;
    logic [QW-1:0]         rr_last_q, rr_last_d;

    logic [NB_QUEUES-1:0]  q_full_c;
    logic [NB_QUEUES-1:0]  retry_req_c;
    logic [QW-1:0]         gnt_idx_c;
    logic                  gnt_valid_c;
    logic                  advance_c;
    logic                  accept_c;
    logic                  do_retry_c;

    // Fullness per queue; a head write landing this cycle is seen immediately.
    always_comb begin
        q_full_c = '0;
        for (int unsigned q = 0; q < NB_QUEUES; q++) begin
            q_full_c[q] = (AW'(tail_q[q] + AW'(1)) ==
                           ((head_wr_valid && (head_wr_queue_id == QW'(q))) ? head_wr_value : head_q[q]));
        end
    end

    assign retry_req_c = pend_q & ~q_full_c;

    rr_pending_arbiter #(
        .NB_QUEUES (NB_QUEUES)
    ) u_rr_pending_arbiter (
        .req_i         (retry_req_c),
        .last_i        (rr_last_q),
        .gnt_idx_c_o   (gnt_idx_c),
        .gnt_valid_c_o (gnt_valid_c)
    );

    assign advance_c     = !out_valid_q || out_meta_ready;
    assign in_meta_ready = !rst && advance_c && !gnt_valid_c;
    assign accept_c      = in_meta_valid && in_meta_ready;
    assign do_retry_c    = !rst && advance_c && gnt_valid_c;

    // Next-state: retry beats input; a full queue defers the descriptor and forwards meta alone.
    always_comb begin
        tail_d      = tail_q;
        head_d      = head_q;
        pmeta_d     = pmeta_q;
        pend_d      = pend_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        full_cnt_d  = full_cnt_q;
        retry_cnt_d = retry_cnt_q;
        rr_last_d   = rr_last_q;

        if (head_wr_valid) begin
            head_d[head_wr_queue_id] = head_wr_value;
        end

        if (do_retry_c) begin
            out_d.meta           = DSC_META_W'(pmeta_q[gnt_idx_c]);
            out_d.needs_dsc      = 1'b1;
            out_d.queue_id       = DSC_QID_W'(gnt_idx_c);
            out_d.slot           = DSC_SLOT_W'(tail_q[gnt_idx_c]);
            out_d.is_retry       = 1'b1;
            out_valid_d          = 1'b1;
            tail_d[gnt_idx_c]    = AW'(tail_q[gnt_idx_c] + AW'(1));
            pend_d[gnt_idx_c]    = 1'b0;
            retry_cnt_d          = retry_cnt_q + 32'd1;
            rr_last_d            = gnt_idx_c;
        end else if (accept_c) begin
            out_d.meta      = DSC_META_W'(in_meta_data);
            out_d.needs_dsc = 1'b0;
            out_d.queue_id  = DSC_QID_W'(in_dsc_queue_id);
            out_d.slot      = '0;
            out_d.is_retry  = 1'b0;
            out_valid_d     = 1'b1;
            if (in_needs_dsc) begin
                if (!q_full_c[in_dsc_queue_id]) begin
                    out_d.needs_dsc         = 1'b1;
                    out_d.slot              = DSC_SLOT_W'(tail_q[in_dsc_queue_id]);
                    tail_d[in_dsc_queue_id] = AW'(tail_q[in_dsc_queue_id] + AW'(1));
                end else begin
                    pend_d[in_dsc_queue_id]  = 1'b1;
                    pmeta_d[in_dsc_queue_id] = in_meta_data;
                    full_cnt_d               = full_cnt_q + 32'd1;
                end
            end
        end else if (advance_c) begin
            out_valid_d = 1'b0;
        end
    end

    // State registers; reset drops the held beat and every deferred descriptor.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned q = 0; q < NB_QUEUES; q++) begin
                tail_q[q]  <= '0;
                head_q[q]  <= '0;
                pmeta_q[q] <= '0;
            end
            pend_q      <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            full_cnt_q  <= '0;
            retry_cnt_q <= '0;
            rr_last_q   <= '0;
        end else begin
            tail_q      <= tail_d;
            head_q      <= head_d;
            pmeta_q     <= pmeta_d;
            pend_q      <= pend_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            full_cnt_q  <= full_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            rr_last_q   <= rr_last_d;
        end
    end

    assign out_meta_data    = META_WIDTH'(out_q.meta);
    assign out_needs_dsc    = out_q.needs_dsc;
    assign out_dsc_queue_id = QW'(out_q.queue_id);
    assign out_dsc_slot     = AW'(out_q.slot);
    assign out_is_retry     = out_q.is_retry;
    assign out_meta_valid   = out_valid_q;
    assign full_cnt         = full_cnt_q;
    assign retry_cnt        = retry_cnt_q;

endmodule
